uart_tx_controller: RTL
=======================

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum data bits per frame.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port txValid  input  1  frame request.
REQ-005 SHALL have port txReady  output  1  controller can accept a frame.
REQ-006 SHALL have port txData  input  DATA_WIDTH  payload; only the low dataType bits are sent.
REQ-007 SHALL have port dataType  input  4  data bits per frame; legal values are 5 to 8.
REQ-008 SHALL have port parityEnable  input  1  parity bit present.
REQ-009 SHALL have port parityType  input  1  0 = even, 1 = odd.
REQ-010 SHALL have port stopBits  input  2  stop bit count; legal values are 1 or 2.
REQ-011 SHALL have port overSampling  input  5  ticks per bit; legal values are 13 or 16.
REQ-012 SHALL have port clkDivisor  input  16  clock cycles per oversample tick; must be nonzero.
REQ-013 SHALL have port tx  output  1  serial line; idles at 1.
REQ-014 SHALL have port busy  output  1  frame in progress.
REQ-015 SHALL have port frameDone  output  1  one-cycle pulse at frame end.
REQ-016 SHALL have port configError  output  1  one-cycle pulse when an illegal configuration is accepted.

Function
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL drive txReady = (state == IDLE) and busy = (state != IDLE).
REQ-019 SHALL accept a frame in a cycle where txValid && txReady; that same edge SHALL latch txData and all configuration inputs, and configuration changes after acceptance SHALL be ignored until the next acceptance.
REQ-020 SHALL, when an accepted configuration is illegal (dataType outside 5-8, overSampling not 13/16, stopBits not 1/2, or clkDivisor == 0), pulse configError for 1 cycle, drop the frame, stay in IDLE, and leave tx at 1.
REQ-021 SHALL, on a legal acceptance at edge N, enter START with registered tx = 0 visible after edge N.
REQ-022 SHALL use a cycle counter 0..clkDivisor-1 to generate a tick, and a tick counter 0..overSampling-1 to mark the bit boundary; one bit time SHALL equal overSampling × clkDivisor cycles.
REQ-023 SHALL clear both counters on acceptance and at every state change.
REQ-024 SHALL, in START, hold tx = 0 for 1 bit time, then go to DATA.
REQ-025 SHALL, in DATA, send dataType bits LSB first, one bit time each, then go to PARITY if parityEnable is set, otherwise to STOP.
REQ-026 SHALL, in PARITY, send for 1 bit time the XOR of the sent data bits for even parity, or its inverse for odd parity; bits above dataType SHALL be excluded.
REQ-027 SHALL, in STOP, hold tx = 1 for stopBits bit times.
REQ-028 SHALL, on the final stop bit boundary, enter IDLE with frameDone = 1 in that first IDLE cycle.
REQ-029 SHALL be able to accept a new frame in that same cycle, so back-to-back frames have no gap beyond the stop bits.
REQ-030 SHALL have total frame length = (1 + dataType + parityEnable + stopBits) × overSampling × clkDivisor cycles, measured from acceptance to frameDone.
REQ-031 SHALL hold tx = 1 in IDLE.

Reset
REQ-032 SHALL, while reset = 0 (at any time, including mid-frame), force state IDLE, tx = 1, txReady = 1, busy = 0, frameDone = 0, configError = 0, all counters and shift register to 0, discarding any partial frame.
REQ-033 SHALL accept a frame on the first rising clock edge after reset deasserts.

Verification
REQ-034 Bench SHALL cover: clkDivisor = 2, overSampling = 16, 8N1, txData = 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 32 cycles; frameDone 320 cycles after acceptance.
REQ-035 Bench SHALL cover: dataType = 7, parity even, txData = 0xC1 -> data bits 1,0,0,0,0,0,1 (bit 7 ignored), parity 0; same stimulus with odd parity -> parity 1.
REQ-036 Bench SHALL cover: dataType = 5, stopBits = 2, overSampling = 13, clkDivisor = 1, no parity -> frame of 8 bits × 13 = 104 cycles, with the final 26 cycles at tx = 1.
REQ-037 Bench SHALL cover: dataType = 4 with txValid = 1 -> configError pulses for 1 cycle, tx stays 1, busy stays 0, txReady = 1 on the next cycle.
REQ-038 Bench SHALL cover: reset asserted during the 3rd DATA bit -> tx = 1 and busy = 0 immediately (asynchronously); after release, a new frame 0x3C transmits correctly.
REQ-039 Bench SHALL cover: txValid held high for two frames 0x55 then 0xAA, with dataType changed mid-first-frame -> first frame is unaffected; second frame's START begins 1 cycle after the first frameDone cycle, with no idle bit between frames.

Source files
------------

// File: rtl/uart_tx_controller.sv
// uart_tx_controller
// Serialises one asynchronous-serial frame per accepted request:
// a start bit, then dataType data bits LSB first, then an optional parity bit,
// then stopBits stop bits. One bit lasts overSampling * clkDivisor clock cycles.
// The payload and the whole line configuration are captured when a request is
// accepted, so the inputs may change freely while a frame is on the line.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         asynchronous active-low reset
//   txValid       frame request
//   txReady       high in IDLE, a request is accepted when txValid && txReady
//   txData        payload, only the low dataType bits are sent
//   dataType      data bits per frame (5..8)
//   parityEnable  append a parity bit
//   parityType    0 = even, 1 = odd
//   stopBits      stop bit count (1 or 2)
//   overSampling  oversample ticks per bit (13 or 16)
//   clkDivisor    clock cycles per oversample tick (nonzero)
//   tx            registered serial line, idles high
//   busy          frame in progress
//   frameDone     one-cycle pulse in the first IDLE cycle after a frame
//   configError   one-cycle pulse when a request with an illegal configuration is dropped
module uart_tx_controller #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  txValid,
    output logic                  txReady,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic [3:0]            dataType,
    input  logic                  parityEnable,
    input  logic                  parityType,
    input  logic [1:0]            stopBits,
    input  logic [4:0]            overSampling,
    input  logic [15:0]           clkDivisor,
    output logic                  tx,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  configError
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity over the low nbits of data; starting from 'odd' yields the
    // inverted (odd) parity bit directly.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic [3:0]            nbits,
                                         input logic                  odd);
        logic p;
        p = odd;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(nbits)) begin
                p = p ^ data[i];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [15:0]             cyc_r;
    logic [4:0]              tick_r;
    logic [3:0]              bit_r;
    logic [1:0]              stop_cnt_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic                    parity_r;
    logic [3:0]              dtype_r;
    logic                    par_en_r;
    logic [1:0]              stop_r;
    logic [4:0]              os_r;
    logic [15:0]             div_r;
    logic                    tx_r, frame_done_r, cfg_err_r;

    logic                    tx_nxt_s, done_nxt_s, err_nxt_s;
    logic                    load_s, shift_s, stop_inc_s;
    logic                    cfg_legal_s, bit_end_s, clear_s;

    assign cfg_legal_s = (dataType >= 4'd5) && (dataType <= 4'd8) &&
                         (int'(dataType) <= DATA_WIDTH) &&
                         ((overSampling == 5'd13) || (overSampling == 5'd16)) &&
                         ((stopBits == 2'd1) || (stopBits == 2'd2)) &&
                         (clkDivisor != 16'd0);

    // Last cycle of the current bit time.
    assign bit_end_s = (cyc_r == (div_r - 16'd1)) && (tick_r == (os_r - 5'd1));

    // Any state change (including acceptance) restarts the bit timing.
    assign clear_s = (state_nxt_s != state_r);

    assign tx          = tx_r;
    assign frameDone   = frame_done_r;
    assign configError = cfg_err_r;
    assign txReady     = (state_r == IDLE);
    assign busy        = (state_r != IDLE);

    // Next-state and next-output decode; tx is computed one cycle ahead so the
    // registered line changes exactly on the bit boundary edge.
    always_comb begin
        state_nxt_s = state_r;
        tx_nxt_s    = 1'b1;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        stop_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (txValid) begin
                    if (cfg_legal_s) begin
                        state_nxt_s = START;
                        tx_nxt_s    = 1'b0;
                        load_s      = 1'b1;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            START: begin
                tx_nxt_s = 1'b0;
                if (bit_end_s) begin
                    state_nxt_s = DATA;
                    tx_nxt_s    = shift_r[0];
                end else begin
                    tx_nxt_s = 1'b0;
                end
            end
            DATA: begin
                tx_nxt_s = shift_r[0];
                if (bit_end_s) begin
                    if (bit_r == (dtype_r - 4'd1)) begin
                        if (par_en_r) begin
                            state_nxt_s = PARITY;
                            tx_nxt_s    = parity_r;
                        end else begin
                            state_nxt_s = STOP;
                            tx_nxt_s    = 1'b1;
                        end
                    end else begin
                        shift_s  = 1'b1;
                        tx_nxt_s = shift_r[1];
                    end
                end else begin
                    tx_nxt_s = shift_r[0];
                end
            end
            PARITY: begin
                tx_nxt_s = parity_r;
                if (bit_end_s) begin
                    state_nxt_s = STOP;
                    tx_nxt_s    = 1'b1;
                end else begin
                    tx_nxt_s = parity_r;
                end
            end
            STOP: begin
                tx_nxt_s = 1'b1;
                if (bit_end_s) begin
                    if (stop_cnt_r == (stop_r - 2'd1)) begin
                        state_nxt_s = IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        stop_inc_s = 1'b1;
                    end
                end else begin
                    stop_inc_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

    // State register and registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            tx_r         <= 1'b1;
            frame_done_r <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            tx_r         <= tx_nxt_s;
            frame_done_r <= done_nxt_s;
            cfg_err_r    <= err_nxt_s;
        end
    end

    // Cycle and tick counters; the tick counter advances when the cycle counter wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_r  <= 16'd0;
            tick_r <= 5'd0;
        end else if (clear_s || (state_r == IDLE)) begin
            cyc_r  <= 16'd0;
            tick_r <= 5'd0;
        end else if (cyc_r == (div_r - 16'd1)) begin
            cyc_r <= 16'd0;
            if (tick_r == (os_r - 5'd1)) begin
                tick_r <= 5'd0;
            end else begin
                tick_r <= tick_r + 5'd1;
            end
        end else begin
            cyc_r <= cyc_r + 16'd1;
        end
    end

    // Frame capture on acceptance, then data shifting and stop-bit counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r    <= '0;
            parity_r   <= 1'b0;
            dtype_r    <= 4'd0;
            par_en_r   <= 1'b0;
            stop_r     <= 2'd0;
            os_r       <= 5'd0;
            div_r      <= 16'd0;
            bit_r      <= 4'd0;
            stop_cnt_r <= 2'd0;
        end else if (load_s) begin
            shift_r    <= txData;
            parity_r   <= calc_parity(txData, dataType, parityType);
            dtype_r    <= dataType;
            par_en_r   <= parityEnable;
            stop_r     <= stopBits;
            os_r       <= overSampling;
            div_r      <= clkDivisor;
            bit_r      <= 4'd0;
            stop_cnt_r <= 2'd0;
        end else begin
            if (shift_s) begin
                shift_r <= shift_r >> 1;
                bit_r   <= bit_r + 4'd1;
            end
            if (stop_inc_s) begin
                stop_cnt_r <= stop_cnt_r + 2'd1;
            end
        end
    end

endmodule
